// File: rtl/riscv_pkg.sv
// riscv_pkg: writeback source encodings and load funct3 constants
package riscv_pkg;
  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a loaded word and extends it
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word_i[{offset_i, 3'b000} +: 8];
    h = word_i[{offset_i[1], 4'b0000} +: 16];
    data_o = funct3_i == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
             funct3_i == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
             funct3_i == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
             funct3_i == F3_LHU ? {{(XLEN-16){1'b0}}, h} : word_i;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register, writeback mux and retired-instruction counter
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 64,
  parameter bit ENABLE_INSTRET = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_w,
  input  logic             flush_w,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  output logic             reg_write_w,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] instret
);
  logic            valid_q, valid_d, we_q, we_d, load_en;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      src_q, src_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] alu_q, alu_d, rdata_q, rdata_d, pc4_q, pc4_d, load_val;
  always_comb begin
    load_en = !flush_w && !stall_w;
    valid_d = flush_w ? 1'b0 : stall_w ? valid_q : valid_m;
    we_d    = flush_w ? 1'b0 : stall_w ? we_q : reg_write_m && valid_m && (rd_m != 5'd0);
    rd_d    = flush_w ? '0 : stall_w ? rd_q : rd_m;
    src_d   = flush_w ? '0 : stall_w ? src_q : result_src_m;
    f3_d    = flush_w ? '0 : stall_w ? f3_q : funct3_m;
    alu_d   = flush_w ? '0 : stall_w ? alu_q : alu_result_m;
    rdata_d = flush_w ? '0 : stall_w ? rdata_q : read_data_m;
    pc4_d   = flush_w ? '0 : stall_w ? pc4_q : pc_plus4_m;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      src_q   <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      src_q   <= src_d;
      f3_q    <= f3_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc4_q   <= pc4_d;
    end
  end
  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i(f3_q),
    .offset_i(alu_q[1:0]),
    .word_i  (rdata_q),
    .data_o  (load_val)
  );
  // Writeback value depends only on W registers so it holds until the regfile's negedge write
  always_comb begin
    result_w = src_q == RESULT_LOAD ? load_val : src_q == RESULT_PC4 ? pc4_q : alu_q;
  end
  assign reg_write_w = we_q;
  assign rd_w        = rd_q;
  assign valid_w     = valid_q;
  if (ENABLE_INSTRET) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else if (load_en && valid_m) cnt_q <= cnt_q + CNT_W'(1);
    end
    assign instret = cnt_q;
  end else begin : g_nocnt
    assign instret = '0;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed stimulus checked against a behavioural writeback model
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_w = 1'b0, flush_w = 1'b0, valid_m = 1'b0, reg_write_m = 1'b0;
  logic [4:0]  rd_m = '0;
  logic [1:0]  result_src_m = '0;
  logic [2:0]  funct3_m = '0;
  logic [31:0] alu_result_m = '0, read_data_m = '0, pc_plus4_m = '0;
  logic        reg_write_w, valid_w, reg_write_s, valid_s;
  logic [4:0]  rd_w, rd_s;
  logic [31:0] result_w, result_s;
  logic [63:0] instret;
  logic [3:0]  instret_s;
  int total = 0, bad = 0;
  bit chk_on = 0;
  logic        m_valid, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic [63:0] m_cnt;
  logic [3:0]  m_cnt4;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .valid_w(valid_w), .instret(instret)
  );

  mem_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .result_src_m(result_src_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .reg_write_w(reg_write_s),
    .rd_w(rd_s), .result_w(result_s), .valid_w(valid_s), .instret(instret_s)
  );

  function automatic logic [31:0] ref_wb(input logic [1:0] src, input logic [2:0] f3,
                                          input logic [31:0] addr, word, pc4);
    longint v;
    int off;
    off = int'(addr[1:0]);
    if (src == 2'b10) return pc4;
    if (src != 2'b01) return addr;
    case (f3)
      3'b000, 3'b100: begin
        v = (longint'(word) >> (8 * off)) & 255;
        if (f3 == 3'b000 && v >= 128) v -= 256;
      end
      3'b001, 3'b101: begin
        v = (longint'(word) >> (16 * (off / 2))) & 65535;
        if (f3 == 3'b001 && v >= 32768) v -= 65536;
      end
      default: v = longint'(word);
    endcase
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 0; m_we <= 0; m_rd <= 0; m_res <= 0; m_cnt <= 0; m_cnt4 <= 0;
    end else if (flush_w) begin
      m_valid <= 0; m_we <= 0; m_rd <= 0; m_res <= 0;
    end else if (!stall_w) begin
      m_valid <= valid_m;
      m_we    <= valid_m && reg_write_m && rd_m != 0;
      m_rd    <= rd_m;
      m_res   <= ref_wb(result_src_m, funct3_m, alu_result_m, read_data_m, pc_plus4_m);
      if (valid_m) begin
        m_cnt  <= m_cnt + 1;
        m_cnt4 <= m_cnt4 + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_valid", 64'(valid_w), 64'(m_valid));
      chk("model_we", 64'(reg_write_w), 64'(m_we));
      chk("model_rd", 64'(rd_w), 64'(m_rd));
      chk("model_result", 64'(result_w), 64'(m_res));
      chk("model_instret", instret, m_cnt);
      chk("model_instret4", 64'(instret_s), 64'(m_cnt4));
    end
  end

  task automatic cyc(input logic v, we, input logic [4:0] rd, input logic [1:0] src,
                     input logic [2:0] f3, input logic [31:0] alu, rdat, pc4,
                     input logic st, fl);
    valid_m = v; reg_write_m = we; rd_m = rd; result_src_m = src; funct3_m = f3;
    alu_result_m = alu; read_data_m = rdat; pc_plus4_m = pc4; stall_w = st; flush_w = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D = 32'h80FF7F01;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 64'(result_w), 64'h0);
    chk("reset_valid", 64'(valid_w), 64'h0);
    chk("reset_instret", instret, 64'h0);
    reset_n = 1'b1;
    chk_on = 1;
    cyc(1, 1, 1, 2'b01, 3'b000, 32'd0, D, 0, 0, 0); chk("lb_off0", 64'(result_w), 64'h00000001);
    cyc(1, 1, 1, 2'b01, 3'b000, 32'd1, D, 0, 0, 0); chk("lb_off1", 64'(result_w), 64'h0000007F);
    cyc(1, 1, 1, 2'b01, 3'b000, 32'd2, D, 0, 0, 0); chk("lb_off2", 64'(result_w), 64'hFFFFFFFF);
    cyc(1, 1, 1, 2'b01, 3'b000, 32'd3, D, 0, 0, 0); chk("lb_off3", 64'(result_w), 64'hFFFFFF80);
    cyc(1, 1, 1, 2'b01, 3'b100, 32'd3, D, 0, 0, 0); chk("lbu_off3", 64'(result_w), 64'h00000080);
    cyc(1, 1, 1, 2'b01, 3'b001, 32'd2, D, 0, 0, 0); chk("lh_off2", 64'(result_w), 64'hFFFF80FF);
    cyc(1, 1, 1, 2'b01, 3'b101, 32'd2, D, 0, 0, 0); chk("lhu_off2", 64'(result_w), 64'h000080FF);
    cyc(1, 1, 1, 2'b01, 3'b001, 32'd0, D, 0, 0, 0); chk("lh_off0", 64'(result_w), 64'h00007F01);
    cyc(1, 1, 5, 2'b00, 3'b000, 32'h1234, D, 32'h8, 0, 0);
    chk("alu_result", 64'(result_w), 64'h1234);
    chk("alu_we", 64'(reg_write_w), 64'h1);
    chk("alu_rd", 64'(rd_w), 64'h5);
    cyc(1, 1, 6, 2'b10, 3'b000, 32'h999, D, 32'h104, 0, 0); chk("pc4_result", 64'(result_w), 64'h104);
    cyc(1, 1, 0, 2'b00, 3'b000, 32'h55, D, 0, 0, 0); chk("x0_we", 64'(reg_write_w), 64'h0);
    cyc(1, 1, 7, 2'b00, 3'b000, 32'hABCD, D, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 9, 2'b10, 3'b000, 32'h5555, D, 32'h200, 1, 0);
      chk("stall_result", 64'(result_w), 64'hABCD);
      chk("stall_rd", 64'(rd_w), 64'h7);
    end
    chk("stall_instret", instret, 64'd12);
    cyc(1, 1, 9, 2'b00, 3'b000, 32'h5555, D, 0, 1, 1);
    chk("flush_valid", 64'(valid_w), 64'h0);
    chk("flush_we", 64'(reg_write_w), 64'h0);
    chk("flush_instret", instret, 64'd12);
    cyc(1, 1, 4, 2'b00, 3'b000, 32'h77, D, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(valid_w), 64'h0);
    chk("midreset_we", 64'(reg_write_w), 64'h0);
    chk("midreset_rd", 64'(rd_w), 64'h0);
    chk("midreset_result", 64'(result_w), 64'h0);
    chk("midreset_instret", instret, 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 3, 2'b00, 3'b000, 32'h33, D, 0, 0, 0);
    chk("bubble_we", 64'(reg_write_w), 64'h0);
    chk("bubble_instret", instret, 64'h0);
    cyc(1, 1, 2, 2'b01, 3'b010, 32'd2, D, 0, 0, 0); chk("lw_off2", 64'(result_w), 64'h80FF7F01);
    cyc(1, 1, 2, 2'b11, 3'b000, 32'h77, D, 32'h10, 0, 0); chk("src11_alu", 64'(result_w), 64'h77);
    cyc(1, 1, 2, 2'b01, 3'b011, 32'd1, D, 0, 0, 0); chk("f3_011_word", 64'(result_w), 64'h80FF7F01);
    chk("instret_3", instret, 64'd3);
    for (int i = 0; i < 13; i++) cyc(1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), D, 0, 0, 0);
    chk("instret_16", instret, 64'd16);
    chk("instret_wrap", 64'(instret_s), 64'h0);
    cyc(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
